// File: rtl/rom_arbiter_pkg.sv
// Shared definitions for the ROM arbiter and its round-robin picker.
//   arb_state_e : FSM state encoding (idle / read issued / data returning)
//   DefAddrW    : default ROM address width
//   DefDataW    : default ROM data width
//   clog2()     : index width helper for pointer/owner registers (minimum 1)
package rom_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StLatch = 2'd2
  } arb_state_e;

  localparam int unsigned DefAddrW = 4;
  localparam int unsigned DefDataW = 8;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/rom_rr_picker.sv
// Combinational round-robin picker.
//   req_i    : per-requester request bits
//   ptr_i    : index of the last winner; search starts at ptr_i+1 (mod NUM_REQ)
//   winner_o : index of the first requester found
//   found_o  : high when any request is set
module rom_rr_picker
  import rom_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdxW-1:0]    ptr_i,
  output logic [IdxW-1:0]    winner_o,
  output logic               found_o
);

  logic [IdxW-1:0] cand;

  always_comb begin
    winner_o = '0;
    found_o  = 1'b0;
    cand     = '0;
    // Offset NUM_REQ wraps back to the pointer itself, so the last winner has lowest priority.
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = IdxW'((ptr_i + off) % NUM_REQ);
      if (!found_o && req_i[cand]) begin
        found_o  = 1'b1;
        winner_o = cand;
      end
    end
  end

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one synchronous-read ROM (1-cycle latency) among NUM_REQ clients.
//   Clock, Reset    : system clock, asynchronous active-low reset
//   Request_i       : per-requester level request, held until Grant_o
//   Address_i       : packed addresses, requester k at [k*ADDR_W +: ADDR_W]
//   Grant_o         : one-hot pulse, request accepted and address latched
//   Valid_o         : one-hot pulse, Data_o holds that requester's word
//   Data_o          : last captured ROM word
//   Busy_o          : high while a read is in flight
//   RomReadEnable_o : ROM read enable
//   RomAddress_o    : ROM address
//   RomData_i       : ROM registered data
module rom_arbiter
  import rom_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = DefAddrW,
  parameter int unsigned DATA_W  = DefDataW
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [NUM_REQ-1:0]        Request_i,
  input  logic [NUM_REQ*ADDR_W-1:0] Address_i,
  output logic [NUM_REQ-1:0]        Grant_o,
  output logic [NUM_REQ-1:0]        Valid_o,
  output logic [DATA_W-1:0]         Data_o,
  output logic                      Busy_o,
  output logic                      RomReadEnable_o,
  output logic [ADDR_W-1:0]         RomAddress_o,
  input  logic [DATA_W-1:0]         RomData_i
);

  localparam int unsigned IdxW = clog2(NUM_REQ);

  arb_state_e          state_q;
  logic [IdxW-1:0]     ptr_q;
  logic [IdxW-1:0]     owner_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [NUM_REQ-1:0]  valid_q;
  logic [DATA_W-1:0]   data_q;
  logic                ren_q;
  logic [ADDR_W-1:0]   raddr_q;

  logic [IdxW-1:0]     winner;
  logic                found;
  logic [ADDR_W-1:0]   addr_arr [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_addr
    assign addr_arr[k] = Address_i[k*ADDR_W +: ADDR_W];
  end

  rom_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_i    (Request_i),
    .ptr_i    (ptr_q),
    .winner_o (winner),
    .found_o  (found)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      ptr_q   <= IdxW'(NUM_REQ - 1);  // requester 0 gets first priority
      owner_q <= '0;
      grant_q <= '0;
      valid_q <= '0;
      data_q  <= '0;
      ren_q   <= 1'b0;
      raddr_q <= '0;
    end else begin
      grant_q <= '0;
      valid_q <= '0;
      unique case (state_q)
        StRead: begin
          ren_q   <= 1'b0;
          state_q <= StLatch;
        end
        StIdle, StLatch: begin
          // Returning data and the next arbitration share this edge.
          if (state_q == StLatch) begin
            data_q           <= RomData_i;
            valid_q[owner_q] <= 1'b1;
          end
          if (found) begin
            grant_q[winner] <= 1'b1;
            raddr_q         <= addr_arr[winner];
            ren_q           <= 1'b1;
            ptr_q           <= winner;
            owner_q         <= winner;
            state_q         <= StRead;
          end else begin
            ren_q   <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: begin
          ren_q   <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign Grant_o         = grant_q;
  assign Valid_o         = valid_q;
  assign Data_o          = data_q;
  assign Busy_o          = (state_q != StIdle);
  assign RomReadEnable_o = ren_q;
  assign RomAddress_o    = raddr_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with a behavioural 16x8 synchronous-read ROM.
module tb_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [15:0] addr = '0;
  logic [3:0]  grant, valid;
  logic [7:0]  data;
  logic        busy, rom_re;
  logic [3:0]  rom_addr;
  logic [7:0]  rom_q = '0;

  int checks = 0;
  int failures = 0;
  int vcount [4] = '{default: 0};

  always #5 clk = ~clk;

  rom_arbiter #(
    .NUM_REQ (4),
    .ADDR_W  (4),
    .DATA_W  (8)
  ) dut (
    .Clock           (clk),
    .Reset           (rst),
    .Request_i       (req),
    .Address_i       (addr),
    .Grant_o         (grant),
    .Valid_o         (valid),
    .Data_o          (data),
    .Busy_o          (busy),
    .RomReadEnable_o (rom_re),
    .RomAddress_o    (rom_addr),
    .RomData_i       (rom_q)
  );

  // ROM contents: word[a] = a*37 + 5 (mod 256)
  function automatic logic [7:0] rom_val(input logic [3:0] a);
    int v;
    v = int'(a) * 37 + 5;
    return v[7:0];
  endfunction

  always @(posedge clk) if (rom_re) rom_q <= rom_val(rom_addr);

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) if (valid[k]) vcount[k]++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst  = 1'b0;
    req  = '0;
    addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst_before;
    logic [3:0]  req;
    logic [15:0] addr;
    logic [3:0]  grant;
    logic [3:0]  valid;
    logic [7:0]  data;
    logic        ren;
    logic [3:0]  raddr;
    logic        busy;
  } vec_t;

  vec_t vecs [15];

  initial begin
    int v1, v3;
    // Single requester 0, address 3.
    vecs[0]  = '{1'b1, 4'b0001, 16'h0003, 4'b0001, 4'b0000, 8'h00,       1'b1, 4'd3, 1'b1};
    vecs[1]  = '{1'b0, 4'b0000, 16'h0003, 4'b0000, 4'b0000, 8'h00,       1'b0, 4'd3, 1'b1};
    vecs[2]  = '{1'b0, 4'b0000, 16'h0003, 4'b0000, 4'b0001, rom_val(3),  1'b0, 4'd3, 1'b0};
    vecs[3]  = '{1'b0, 4'b0000, 16'h0003, 4'b0000, 4'b0000, rom_val(3),  1'b0, 4'd3, 1'b0};
    // All four requesting, addresses 1..4, from reset.
    vecs[4]  = '{1'b1, 4'b1111, 16'h4321, 4'b0001, 4'b0000, 8'h00,       1'b1, 4'd1, 1'b1};
    vecs[5]  = '{1'b0, 4'b1111, 16'h4321, 4'b0000, 4'b0000, 8'h00,       1'b0, 4'd1, 1'b1};
    vecs[6]  = '{1'b0, 4'b1111, 16'h4321, 4'b0010, 4'b0001, rom_val(1),  1'b1, 4'd2, 1'b1};
    vecs[7]  = '{1'b0, 4'b1111, 16'h4321, 4'b0000, 4'b0000, rom_val(1),  1'b0, 4'd2, 1'b1};
    vecs[8]  = '{1'b0, 4'b1111, 16'h4321, 4'b0100, 4'b0010, rom_val(2),  1'b1, 4'd3, 1'b1};
    vecs[9]  = '{1'b0, 4'b1111, 16'h4321, 4'b0000, 4'b0000, rom_val(2),  1'b0, 4'd3, 1'b1};
    vecs[10] = '{1'b0, 4'b1111, 16'h4321, 4'b1000, 4'b0100, rom_val(3),  1'b1, 4'd4, 1'b1};
    vecs[11] = '{1'b0, 4'b1111, 16'h4321, 4'b0000, 4'b0000, rom_val(3),  1'b0, 4'd4, 1'b1};
    vecs[12] = '{1'b0, 4'b1111, 16'h4321, 4'b0001, 4'b1000, rom_val(4),  1'b1, 4'd1, 1'b1};
    vecs[13] = '{1'b0, 4'b0000, 16'h4321, 4'b0000, 4'b0000, rom_val(4),  1'b0, 4'd1, 1'b1};
    vecs[14] = '{1'b0, 4'b0000, 16'h4321, 4'b0000, 4'b0001, rom_val(1),  1'b0, 4'd1, 1'b0};

    do_reset();
    #1;
    chk("reset grant", 32'(grant), 0);
    chk("reset valid", 32'(valid), 0);
    chk("reset data", 32'(data), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset ren", 32'(rom_re), 0);
    chk("reset raddr", 32'(rom_addr), 0);

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].rst_before) do_reset();
      req  = vecs[i].req;
      addr = vecs[i].addr;
      step();
      chk($sformatf("v%0d grant", i), 32'(grant), 32'(vecs[i].grant));
      chk($sformatf("v%0d valid", i), 32'(valid), 32'(vecs[i].valid));
      chk($sformatf("v%0d data", i), 32'(data), 32'(vecs[i].data));
      chk($sformatf("v%0d ren", i), 32'(rom_re), 32'(vecs[i].ren));
      chk($sformatf("v%0d raddr", i), 32'(rom_addr), 32'(vecs[i].raddr));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].busy));
    end

    // Pointer at 2, then 1010 -> requester 3 before requester 1.
    do_reset();
    req = 4'b0100; addr = 16'h0500;
    step();
    chk("rr setup grant", 32'(grant), 32'b0100);
    req = '0;
    step();
    step();
    chk("rr setup valid", 32'(valid), 32'b0100);
    req = 4'b1010; addr = 16'h9060;
    step();
    chk("rr first grant", 32'(grant), 32'b1000);
    chk("rr first raddr", 32'(rom_addr), 9);
    req = 4'b0010;
    step();
    step();
    chk("rr second grant", 32'(grant), 32'b0010);
    chk("rr second raddr", 32'(rom_addr), 6);
    chk("rr first valid", 32'(valid), 32'b1000);
    chk("rr first data", 32'(data), 32'(rom_val(9)));
    req = '0;
    step();
    step();
    chk("rr second valid", 32'(valid), 32'b0010);
    chk("rr second data", 32'(data), 32'(rom_val(6)));

    // Requester 2 sweeps all 16 addresses back to back.
    do_reset();
    req = 4'b0100; addr = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] nxt;
      step();
      chk($sformatf("sweep%0d grant", i), 32'(grant), 32'b0100);
      chk($sformatf("sweep%0d raddr", i), 32'(rom_addr), 32'(i));
      if (i > 0) begin
        chk($sformatf("sweep%0d valid", i - 1), 32'(valid), 32'b0100);
        chk($sformatf("sweep%0d data", i - 1), 32'(data), 32'(rom_val(4'(i - 1))));
      end
      nxt  = 4'(i + 1);
      addr = {4'h0, nxt, 8'h00};
      if (i == 15) req = '0;
      step();
    end
    step();
    chk("sweep15 valid", 32'(valid), 32'b0100);
    chk("sweep15 data", 32'(data), 32'(rom_val(15)));
    chk("sweep idle busy", 32'(busy), 0);

    // Reset asserted while a read is in READ.
    v3 = vcount[3];
    req = 4'b1111; addr = 16'h4321;
    step();
    chk("midrst grant", 32'(grant), 32'b1000);
    rst = 1'b0;
    #1;
    chk("midrst grant0", 32'(grant), 0);
    chk("midrst ren0", 32'(rom_re), 0);
    chk("midrst raddr0", 32'(rom_addr), 0);
    chk("midrst data0", 32'(data), 0);
    chk("midrst busy0", 32'(busy), 0);
    chk("midrst valid0", 32'(valid), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("postrst grant", 32'(grant), 32'b0001);
    req = '0;
    step();
    step();
    chk("postrst valid", 32'(valid), 32'b0001);
    chk("postrst data", 32'(data), 32'(rom_val(1)));
    chk("midrst no valid3", 32'(vcount[3] - v3), 0);

    // Requester 1 pulses during another read's READ cycle and withdraws.
    do_reset();
    v1 = vcount[1];
    req = 4'b0001; addr = 16'h0007;
    step();
    chk("wd grant0", 32'(grant), 32'b0001);
    req = 4'b0010; addr = 16'h0087;
    step();
    chk("wd read grant", 32'(grant), 0);
    req = '0;
    step();
    chk("wd latch valid", 32'(valid), 32'b0001);
    chk("wd latch data", 32'(data), 32'(rom_val(7)));
    chk("wd latch grant", 32'(grant), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("wd idle%0d grant", i), 32'(grant), 0);
    end
    chk("wd no valid1", 32'(vcount[1] - v1), 0);
    chk("wd busy", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
